// File: rtl/pll_ctrl_pkg.sv
// Shared types and constants for the PLL control master.
package pll_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_RST  = 3'd1,
    ST_WR_CTRL   = 3'd2,
    ST_RD_BACK   = 3'd3,
    ST_POLL_WAIT = 3'd4,
    ST_POLL_RD   = 3'd5,
    ST_DONE      = 3'd6,
    ST_ERROR     = 3'd7
  } state_t;

  localparam logic [1:0] ERR_OK       = 2'd0;
  localparam logic [1:0] ERR_READBACK = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd2;

  localparam logic [2:0] STATUS_ADDR_DEF = 3'd0;
  localparam logic [2:0] CTRL_ADDR_DEF   = 3'd1;

endpackage

// File: rtl/pll_ctrl_master_if.sv
// Avalon-MM link between the PLL control master and the PLL wrapper slave.
interface pll_ctrl_master_if;
  logic [2:0]  av_address;
  logic        av_chipselect;
  logic        av_read;
  logic        av_write;
  logic [15:0] av_writedata;
  logic [15:0] av_readdata;
  logic        slv_resetreq;

  modport master (
    output av_address, av_chipselect, av_read, av_write, av_writedata,
    input  av_readdata, slv_resetreq
  );

  modport slave (
    input  av_address, av_chipselect, av_read, av_write, av_writedata,
    output av_readdata, slv_resetreq
  );
endinterface

// File: rtl/pll_ctrl_timer.sv
// Poll-interval down-counter: load starts a window of INTERVAL enabled cycles,
// expired is high in the last cycle of that window.
module pll_ctrl_timer #(
  parameter int INTERVAL = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic load,
  input  logic enable,
  output logic expired
);
  localparam int W = $clog2(INTERVAL + 1);

  logic [W-1:0] cnt;

  // Count down while enabled, stop at zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      cnt <= '0;
    else if (load)
      cnt <= W'(INTERVAL - 1);
    else if (enable && cnt != '0)
      cnt <= cnt - 1'b1;
  end

  assign expired = (cnt == '0);
endmodule

// File: rtl/pll_ctrl_master.sv
// Avalon-MM master that writes a PLL control word, reads it back and polls
// the status register until lock or timeout.
module pll_ctrl_master
  import pll_ctrl_pkg::*;
#(
  parameter int         POLL_INTERVAL = 16,
  parameter int         TIMEOUT_POLLS = 255,
  parameter logic [2:0] STATUS_ADDR   = STATUS_ADDR_DEF,
  parameter logic [2:0] CTRL_ADDR     = CTRL_ADDR_DEF,
  parameter int         LOCK_BIT      = 0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [15:0]           cmd_ctrl_word,
  output logic                  busy,
  output logic                  done,
  output logic [1:0]            err_code,
  output logic [15:0]           last_status,
  pll_ctrl_master_if.master     bus
);

  state_t      state, state_nx;
  logic [15:0] word;
  logic [15:0] poll_cnt;
  logic [15:0] poll_inc;
  logic        accept;
  logic        match;
  logic        locked;
  logic        timed_out;
  logic        timer_load;
  logic        timer_expired;

  assign accept    = (state == ST_IDLE) && cmd_valid;
  assign match     = (bus.av_readdata == word);
  assign locked    = bus.av_readdata[LOCK_BIT];
  assign poll_inc  = (poll_cnt == 16'hFFFF) ? poll_cnt : poll_cnt + 16'd1;
  assign timed_out = (poll_inc >= 16'(TIMEOUT_POLLS));

  // A fresh interval starts whenever the FSM is about to enter POLL_WAIT.
  assign timer_load = ((state == ST_RD_BACK) && match) ||
                      ((state == ST_POLL_RD) && !locked && !timed_out);

  pll_ctrl_timer #(.INTERVAL(POLL_INTERVAL)) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (timer_load),
    .enable  (state == ST_POLL_WAIT),
    .expired (timer_expired)
  );

  // Next-state selection.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:      if (cmd_valid) state_nx = ST_WAIT_RST;
      ST_WAIT_RST:  if (!bus.slv_resetreq) state_nx = ST_WR_CTRL;
      ST_WR_CTRL:   state_nx = ST_RD_BACK;
      ST_RD_BACK:   state_nx = match ? ST_POLL_WAIT : ST_ERROR;
      ST_POLL_WAIT: if (timer_expired) state_nx = ST_POLL_RD;
      ST_POLL_RD: begin
        if (locked)         state_nx = ST_DONE;
        else if (timed_out) state_nx = ST_ERROR;
        else                state_nx = ST_POLL_WAIT;
      end
      ST_DONE:      state_nx = ST_IDLE;
      ST_ERROR:     state_nx = ST_IDLE;
      default:      state_nx = ST_IDLE;
    endcase
  end

  // State register plus transaction data latched along the way.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      word        <= '0;
      err_code    <= ERR_OK;
      last_status <= '0;
      poll_cnt    <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        word        <= cmd_ctrl_word;
        err_code    <= ERR_OK;
        last_status <= '0;
        poll_cnt    <= '0;
      end
      if (state == ST_RD_BACK && !match)
        err_code <= ERR_READBACK;
      if (state == ST_POLL_RD) begin
        last_status <= bus.av_readdata;
        poll_cnt    <= poll_inc;
        if (!locked && timed_out)
          err_code <= ERR_TIMEOUT;
      end
    end
  end

  // Bus strobes decode straight from state so reset drops them asynchronously.
  always_comb begin
    bus.av_address    = '0;
    bus.av_chipselect = 1'b0;
    bus.av_read       = 1'b0;
    bus.av_write      = 1'b0;
    bus.av_writedata  = '0;
    case (state)
      ST_WR_CTRL: begin
        bus.av_address    = CTRL_ADDR;
        bus.av_chipselect = 1'b1;
        bus.av_write      = 1'b1;
        bus.av_writedata  = word;
      end
      ST_RD_BACK: begin
        bus.av_address    = CTRL_ADDR;
        bus.av_chipselect = 1'b1;
        bus.av_read       = 1'b1;
      end
      ST_POLL_RD: begin
        bus.av_address    = STATUS_ADDR;
        bus.av_chipselect = 1'b1;
        bus.av_read       = 1'b1;
      end
      default: ;
    endcase
  end

  assign cmd_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE) || (state == ST_ERROR);

endmodule

// File: tb/tb_pll_ctrl_master.sv
// Directed bench for pll_ctrl_master with a behavioural PLL slave model.
module tb_pll_ctrl_master;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [15:0] cmd_ctrl_word = '0;
  logic        busy;
  logic        done;
  logic [1:0]  err_code;
  logic [15:0] last_status;

  logic        resetreq = 1'b0;
  logic        corrupt = 1'b0;
  int          lock_at = 0;
  int          stat_base = 0;

  int          total = 0;
  int          bad = 0;

  logic [15:0] ctrl_reg = '0;
  logic [15:0] model_rd;
  logic [2:0]  last_wr_addr = '0;
  logic [15:0] last_wr_data = '0;
  int          wr_cnt = 0;
  int          rd_ctrl_cnt = 0;
  int          rd_stat_cnt = 0;
  int          cs_bad = 0;

  pll_ctrl_master_if bus();

  pll_ctrl_master #(
    .POLL_INTERVAL (4),
    .TIMEOUT_POLLS (5)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_ctrl_word (cmd_ctrl_word),
    .busy          (busy),
    .done          (done),
    .err_code      (err_code),
    .last_status   (last_status),
    .bus           (bus)
  );

  always #5 clk = ~clk;

  // Slave model: zero-latency read data; status locks on the lock_at-th read.
  always_comb begin
    model_rd = 16'hDEAD;
    if (bus.av_address == 3'd1)
      model_rd = corrupt ? (ctrl_reg ^ 16'h0002) : ctrl_reg;
    else if (bus.av_address == 3'd0)
      model_rd = (lock_at != 0 && (rd_stat_cnt - stat_base + 1) >= lock_at) ? 16'h8001 : 16'h8000;
  end

  assign bus.av_readdata  = model_rd;
  assign bus.slv_resetreq = resetreq;

  // Bus monitor: records every strobe cycle and chipselect protocol errors.
  always @(posedge clk) begin
    if (bus.av_write) begin
      wr_cnt       <= wr_cnt + 1;
      last_wr_addr <= bus.av_address;
      last_wr_data <= bus.av_writedata;
      if (bus.av_address == 3'd1) ctrl_reg <= bus.av_writedata;
    end
    if (bus.av_read) begin
      if (bus.av_address == 3'd1) rd_ctrl_cnt <= rd_ctrl_cnt + 1;
      else if (bus.av_address == 3'd0) rd_stat_cnt <= rd_stat_cnt + 1;
    end
    if ((bus.av_chipselect != (bus.av_read | bus.av_write)) || (bus.av_read && bus.av_write))
      cs_bad <= cs_bad + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic send_cmd(input logic [15:0] w);
    @(negedge clk);
    cmd_ctrl_word = w;
    cmd_valid = 1'b1;
    chk("cmd_ready_at_accept", cmd_ready, 1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < budget);
    chk("done_seen", done, 1);
  endtask

  int n;
  int wr0, rc0, rs0;

  initial begin
    // 1: reset state
    reset_n = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err_code, 0);
    chk("rst_last_status", last_status, 0);
    chk("rst_strobes", {bus.av_chipselect, bus.av_read, bus.av_write}, 0);
    chk("rst_addr_data", {bus.av_address, bus.av_writedata}, 0);
    reset_n = 1'b1;
    @(negedge clk);

    // 2: nominal, lock on third poll
    lock_at = 3; stat_base = rd_stat_cnt;
    wr0 = wr_cnt; rc0 = rd_ctrl_cnt; rs0 = rd_stat_cnt;
    send_cmd(16'h00A5);
    chk("nom_busy", busy, 1);
    chk("nom_not_ready", cmd_ready, 0);
    wait_done(100, n);
    chk("nom_latency", n, 19);
    chk("nom_err", err_code, 0);
    chk("nom_last_status", last_status, 16'h8001);
    chk("nom_writes", wr_cnt - wr0, 1);
    chk("nom_wr_addr", last_wr_addr, 1);
    chk("nom_wr_data", last_wr_data, 16'h00A5);
    chk("nom_ctrl_reads", rd_ctrl_cnt - rc0, 1);
    chk("nom_stat_reads", rd_stat_cnt - rs0, 3);
    @(negedge clk);
    chk("nom_done_pulse", done, 0);
    chk("nom_idle_busy", busy, 0);
    chk("nom_idle_ready", cmd_ready, 1);
    chk("nom_err_held", err_code, 0);

    // 3: resetrequest held for 64 cycles after accept
    resetreq = 1'b1; lock_at = 1; stat_base = rd_stat_cnt;
    wr0 = wr_cnt; rc0 = rd_ctrl_cnt; rs0 = rd_stat_cnt;
    send_cmd(16'h0F0F);
    repeat (64) @(negedge clk);
    chk("rr_no_strobe", (wr_cnt - wr0) + (rd_ctrl_cnt - rc0) + (rd_stat_cnt - rs0), 0);
    chk("rr_busy", busy, 1);
    resetreq = 1'b0;
    wait_done(100, n);
    chk("rr_writes", wr_cnt - wr0, 1);
    chk("rr_wr_data", last_wr_data, 16'h0F0F);
    chk("rr_err", err_code, 0);

    // 4: readback mismatch
    @(negedge clk);
    corrupt = 1'b1; lock_at = 1; stat_base = rd_stat_cnt;
    wr0 = wr_cnt; rc0 = rd_ctrl_cnt; rs0 = rd_stat_cnt;
    send_cmd(16'h00A5);
    wait_done(100, n);
    chk("mm_latency", n, 4);
    chk("mm_err", err_code, 1);
    chk("mm_stat_reads", rd_stat_cnt - rs0, 0);
    chk("mm_ctrl_reads", rd_ctrl_cnt - rc0, 1);
    chk("mm_last_status", last_status, 0);
    @(negedge clk);
    corrupt = 1'b0;

    // 5: lock timeout after five polls
    lock_at = 0; stat_base = rd_stat_cnt;
    wr0 = wr_cnt; rc0 = rd_ctrl_cnt; rs0 = rd_stat_cnt;
    send_cmd(16'h5A5A);
    wait_done(200, n);
    chk("to_latency", n, 29);
    chk("to_err", err_code, 2);
    chk("to_stat_reads", rd_stat_cnt - rs0, 5);
    chk("to_last_status", last_status, 16'h8000);
    @(negedge clk);
    chk("to_err_held", err_code, 2);
    chk("to_status_held", last_status, 16'h8000);

    // 6: reset during POLL_WAIT, then a clean restart
    lock_at = 1; stat_base = rd_stat_cnt;
    send_cmd(16'h4321);
    repeat (4) @(negedge clk);
    chk("ab_busy_before", busy, 1);
    reset_n = 1'b0;
    #1;
    chk("ab_busy", busy, 0);
    chk("ab_ready", cmd_ready, 1);
    chk("ab_err", err_code, 0);
    chk("ab_strobes", {bus.av_chipselect, bus.av_read, bus.av_write}, 0);
    @(negedge clk);
    reset_n = 1'b1;
    stat_base = rd_stat_cnt;
    wr0 = wr_cnt; rc0 = rd_ctrl_cnt; rs0 = rd_stat_cnt;
    send_cmd(16'h1234);
    wait_done(100, n);
    chk("ab_latency", n, 9);
    chk("ab_writes", wr_cnt - wr0, 1);
    chk("ab_wr_addr", last_wr_addr, 1);
    chk("ab_wr_data", last_wr_data, 16'h1234);
    chk("ab_stat_reads", rd_stat_cnt - rs0, 1);
    chk("ab_err_ok", err_code, 0);

    @(negedge clk);
    chk("cs_protocol", cs_bad, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
